frc_caches_dual: RTL and testbench

- Pair of independent force caches used by the force-evaluation pipeline.
- "home" cache holds accumulated forces for home-cell particles; "nb" cache holds them for neighbour-cell particles.
- Each cache is a simple dual-port memory indexed by particle ID: one synchronous write port and one registered read port.
- Each entry is a 3-component single-precision force vector (x, y, z).

---
 rtl/frc_caches_dual.sv | 137 +++++++++++++
 tb/tb_frc_caches_dual.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frc_caches_dual.sv
// -----------------------------------------------------------------------------
// frc_caches_dual
//
// Purpose:
//   Two independent force caches used by the force-evaluation pipeline.
//   "home" holds accumulated forces for home-cell particles and "nb" holds
//   them for neighbour-cell particles. Each cache is a simple dual-port
//   memory indexed by particle ID. It has one synchronous write port and
//   one registered read port. Every entry is a {z,y,x} single-precision
//   force vector, with x in the LSBs. Each entry also has a valid bit, so
//   an entry that has never been written (or was cleared by reset) reads
//   back as 0.0 in all three components.
//
// Optional feature (macro FRC_CACHE_BYPASS_EN):
//   defined   : write-first. A read that hits the address being written on
//               the same edge returns the new write data.
//   undefined : read-first. The same collision returns the prior contents,
//               or 0 if the entry was invalid.
//
// Ports:
//   clk               in   clock, rising edge
//   rst_n             in   asynchronous active-low reset (clears valid bits
//                          and read registers, not memory contents)
//   home_frc_wr_addr  in   home write particle ID
//   home_frc_wr_data  in   home write force vector {z,y,x}
//   home_frc_wr_en    in   home write strobe
//   home_frc_rd_addr  in   home read particle ID
//   nb_frc_wr_addr    in   nb write particle ID
//   nb_frc_wr_data    in   nb write force vector {z,y,x}
//   nb_frc_wr_en      in   nb write strobe
//   nb_frc_rd_addr    in   nb read particle ID
//   home_frc_rd_data  out  home read data, 1-cycle latency, registered
//   nb_frc_rd_data    out  nb read data, 1-cycle latency, registered
// -----------------------------------------------------------------------------
module frc_caches_dual #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int DATA_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PARTICLE_ID_WIDTH-1:0] home_frc_wr_addr,
    input  logic [3*DATA_WIDTH-1:0]      home_frc_wr_data,
    input  logic                         home_frc_wr_en,
    input  logic [PARTICLE_ID_WIDTH-1:0] home_frc_rd_addr,
    input  logic [PARTICLE_ID_WIDTH-1:0] nb_frc_wr_addr,
    input  logic [3*DATA_WIDTH-1:0]      nb_frc_wr_data,
    input  logic                         nb_frc_wr_en,
    input  logic [PARTICLE_ID_WIDTH-1:0] nb_frc_rd_addr,
    output logic [3*DATA_WIDTH-1:0]      home_frc_rd_data,
    output logic [3*DATA_WIDTH-1:0]      nb_frc_rd_data
);

    localparam int VEC_W      = 3 * DATA_WIDTH;
    localparam int DEPTH      = 2 ** PARTICLE_ID_WIDTH;
    localparam int NUM_CACHES = 2;   // index 0 = home, 1 = nb

    // Gather both caches' ports into arrays so one generate body serves both.
    logic                         wr_en_s   [NUM_CACHES];
    logic [PARTICLE_ID_WIDTH-1:0] wr_addr_s [NUM_CACHES];
    logic [VEC_W-1:0]             wr_data_s [NUM_CACHES];
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr_s [NUM_CACHES];
    logic [VEC_W-1:0]             rd_data_s [NUM_CACHES];

    assign wr_en_s[0]   = home_frc_wr_en;
    assign wr_addr_s[0] = home_frc_wr_addr;
    assign wr_data_s[0] = home_frc_wr_data;
    assign rd_addr_s[0] = home_frc_rd_addr;

    assign wr_en_s[1]   = nb_frc_wr_en;
    assign wr_addr_s[1] = nb_frc_wr_addr;
    assign wr_data_s[1] = nb_frc_wr_data;
    assign rd_addr_s[1] = nb_frc_rd_addr;

    assign home_frc_rd_data = rd_data_s[0];
    assign nb_frc_rd_data   = rd_data_s[1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CACHES; gi++) begin : g_cache
            logic [VEC_W-1:0] mem_q [DEPTH];
            logic [DEPTH-1:0] valid_q;
            logic [VEC_W-1:0] rd_data_q;
            logic [VEC_W-1:0] rd_data_d;

            // The memory array has no reset, so it can map onto block RAM.
            // A write that lands while rst_n is low cannot be observed: the
            // valid bit is held clear, and the entry reads 0 until it is
            // rewritten. That rewrite replaces the data anyway.
            always_ff @(posedge clk) begin
                if (wr_en_s[gi]) begin
                    mem_q[wr_addr_s[gi]] <= wr_data_s[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                end else if (wr_en_s[gi]) begin
                    valid_q[wr_addr_s[gi]] <= 1'b1;
                end
            end

            // Read mux. valid_q and mem_q hold the pre-edge state, so the
            // default path is naturally read-first on a collision.
`ifdef FRC_CACHE_BYPASS_EN
            always_comb begin
                rd_data_d = '0;
                if (wr_en_s[gi] && (wr_addr_s[gi] == rd_addr_s[gi])) begin
                    // Write-first: forward the incoming vector. This also
                    // covers an entry whose valid bit is still clear.
                    rd_data_d = wr_data_s[gi];
                end else if (valid_q[rd_addr_s[gi]]) begin
                    rd_data_d = mem_q[rd_addr_s[gi]];
                end
            end
`else
            always_comb begin
                rd_data_d = '0;
                if (valid_q[rd_addr_s[gi]]) begin
                    rd_data_d = mem_q[rd_addr_s[gi]];
                end
            end
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data_s[gi] = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_frc_caches_dual.sv
// -----------------------------------------------------------------------------
// tb_frc_caches_dual
//
// Directed, table-driven bench for frc_caches_dual.
// - Each table row drives one clock edge: write and read inputs for both
//   caches, plus the vectors expected on both outputs after that edge.
// - Hand-written sequences then exercise the asynchronous reset mid-run.
// - The bench is compiled with the same FRC_CACHE_BYPASS_EN setting as the
//   RTL, so collision expectations follow the build.
// -----------------------------------------------------------------------------
module tb_frc_caches_dual;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int VW = 3 * DW;

    localparam logic [DW-1:0] F1 = 32'h3f80_0000;  // 1.0
    localparam logic [DW-1:0] F2 = 32'h4000_0000;  // 2.0
    localparam logic [DW-1:0] F3 = 32'h4040_0000;  // 3.0

    localparam logic [VW-1:0] Z   = '0;
    localparam logic [VW-1:0] V1  = {F1, F1, F1};
    localparam logic [VW-1:0] V2  = {F2, F2, F2};
    localparam logic [VW-1:0] V3  = {F3, F3, F3};
    localparam logic [VW-1:0] MIX = {F3, F2, F1};  // z=3.0, y=2.0, x=1.0

`ifdef FRC_CACHE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] home_frc_wr_addr;
    logic [VW-1:0] home_frc_wr_data;
    logic          home_frc_wr_en;
    logic [AW-1:0] home_frc_rd_addr;
    logic [AW-1:0] nb_frc_wr_addr;
    logic [VW-1:0] nb_frc_wr_data;
    logic          nb_frc_wr_en;
    logic [AW-1:0] nb_frc_rd_addr;
    logic [VW-1:0] home_frc_rd_data;
    logic [VW-1:0] nb_frc_rd_data;

    frc_caches_dual #(
        .PARTICLE_ID_WIDTH(AW),
        .DATA_WIDTH       (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .home_frc_wr_addr (home_frc_wr_addr),
        .home_frc_wr_data (home_frc_wr_data),
        .home_frc_wr_en   (home_frc_wr_en),
        .home_frc_rd_addr (home_frc_rd_addr),
        .nb_frc_wr_addr   (nb_frc_wr_addr),
        .nb_frc_wr_data   (nb_frc_wr_data),
        .nb_frc_wr_en     (nb_frc_wr_en),
        .nb_frc_rd_addr   (nb_frc_rd_addr),
        .home_frc_rd_data (home_frc_rd_data),
        .nb_frc_rd_data   (nb_frc_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hw;
        logic [AW-1:0] ha;
        logic [VW-1:0] hd;
        logic [AW-1:0] hr;
        logic          nw;
        logic [AW-1:0] na;
        logic [VW-1:0] nd;
        logic [AW-1:0] nr;
        logic [VW-1:0] exp_h;
        logic [VW-1:0] exp_n;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic hw, input int ha, input logic [VW-1:0] hd, input int hr,
                                input logic nw, input int na, input logic [VW-1:0] nd, input int nr,
                                input logic [VW-1:0] exp_h, input logic [VW-1:0] exp_n);
        vec_t v;
        v.hw = hw; v.ha = AW'(ha); v.hd = hd; v.hr = AW'(hr);
        v.nw = nw; v.na = AW'(na); v.nd = nd; v.nr = AW'(nr);
        v.exp_h = exp_h; v.exp_n = exp_n;
        return v;
    endfunction

    task automatic drive(input logic hw, input int ha, input logic [VW-1:0] hd, input int hr,
                         input logic nw, input int na, input logic [VW-1:0] nd, input int nr);
        home_frc_wr_en   = hw; home_frc_wr_addr = AW'(ha);
        home_frc_wr_data = hd; home_frc_rd_addr = AW'(hr);
        nb_frc_wr_en     = nw; nb_frc_wr_addr   = AW'(na);
        nb_frc_wr_data   = nd; nb_frc_rd_addr   = AW'(nr);
    endtask

    initial begin
        // Columns: home wr_en, wr_addr, wr_data, rd_addr; the same for nb;
        // then the expected home and nb outputs after the edge.
        vecs[0]  = mk(0, 0, Z,   1,   0, 0,   Z,  1,   Z, Z);                // never written
        vecs[1]  = mk(1, 1, V1,  0,   1, 1,   V1, 0,   Z, Z);                // write 1.0 to addr 1
        vecs[2]  = mk(0, 0, Z,   1,   0, 0,   Z,  1,   V1, V1);              // visible next read
        vecs[3]  = mk(0, 0, Z,   1,   0, 0,   Z,  1,   V1, V1);              // stable
        vecs[4]  = mk(0, 0, Z,   0,   0, 0,   Z,  0,   Z, Z);                // addr 0 invalid
        vecs[5]  = mk(0, 0, Z,   1,   0, 0,   Z,  1,   V1, V1);              // back to 1
        vecs[6]  = mk(1, 1, V2,  1,   1, 1,   V2, 1,   BYP ? V2 : V1, BYP ? V2 : V1); // collision
        vecs[7]  = mk(0, 0, Z,   1,   0, 0,   Z,  1,   V2, V2);              // new data either way
        vecs[8]  = mk(1, 5, V2,  7,   1, 5,   V3, 7,   Z, Z);                // independent writes
        vecs[9]  = mk(0, 0, Z,   5,   0, 0,   Z,  5,   V2, V3);              // home 2.0, nb 3.0
        vecs[10] = mk(1, 9, V3,  9,   0, 0,   Z,  5,   BYP ? V3 : Z, V3);    // collision on invalid
        vecs[11] = mk(0, 0, Z,   9,   1, 127, V1, 127, V3, BYP ? V1 : Z);    // top address
        vecs[12] = mk(1, 0, MIX, 5,   1, 0,   V2, 127, V2, V1);              // different addresses
        vecs[13] = mk(0, 0, Z,   0,   0, 0,   Z,  0,   MIX, V2);             // x in LSBs

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, Z, 0, 0, 0, Z, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_home", home_frc_rd_data, Z);
        chk("reset_nb",   nb_frc_rd_data,   Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].hw, int'(vecs[i].ha), vecs[i].hd, int'(vecs[i].hr),
                  vecs[i].nw, int'(vecs[i].na), vecs[i].nd, int'(vecs[i].nr));
            @(posedge clk);
            #1;
            $display("vec %0d home=%h nb=%h", i, home_frc_rd_data, nb_frc_rd_data);
            chk($sformatf("vec%0d_home", i), home_frc_rd_data, vecs[i].exp_h);
            chk($sformatf("vec%0d_nb", i),   nb_frc_rd_data,   vecs[i].exp_n);
            @(negedge clk);
        end

        // Mid-run reset: outputs hold MIX / V2 here and must clear with no clock edge.
        drive(0, 0, Z, 0, 0, 0, Z, 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset home=%h nb=%h", home_frc_rd_data, nb_frc_rd_data);
        chk("async_rst_home", home_frc_rd_data, Z);
        chk("async_rst_nb",   nb_frc_rd_data,   Z);

        // A write attempted during reset must not become visible.
        @(negedge clk);
        drive(1, 3, V3, 3, 1, 3, V3, 3);
        @(posedge clk);
        #1;
        chk("in_rst_home", home_frc_rd_data, Z);
        @(negedge clk);
        drive(0, 0, Z, 1, 0, 0, Z, 5);
        rst_n = 1'b1;

        // The first edge after release reads previously written addresses: all invalid now.
        @(posedge clk);
        #1;
        $display("post reset rd home=%h nb=%h", home_frc_rd_data, nb_frc_rd_data);
        chk("post_rst_home_a1", home_frc_rd_data, Z);
        chk("post_rst_nb_a5",   nb_frc_rd_data,   Z);
        @(negedge clk);
        drive(0, 0, Z, 3, 0, 0, Z, 3);
        @(posedge clk);
        #1;
        chk("post_rst_home_a3", home_frc_rd_data, Z);
        chk("post_rst_nb_a3",   nb_frc_rd_data,   Z);

        // Rewrite home addr 1. Only home becomes valid again.
        @(negedge clk);
        drive(1, 1, V3, 0, 0, 0, Z, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, Z, 1, 0, 0, Z, 1);
        @(posedge clk);
        #1;
        $display("rewrite home=%h nb=%h", home_frc_rd_data, nb_frc_rd_data);
        chk("rewrite_home", home_frc_rd_data, V3);
        chk("rewrite_nb",   nb_frc_rd_data,   Z);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time guard so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
